// File: rtl/clk_sw_pkg.sv
// rtl/clk_sw_pkg.sv - shared types and constants for the clock switch controller
package clk_sw_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ_UP = 2'd1,
    ST_REQ_DN = 2'd2,
    ST_ERR    = 2'd3
  } sw_state_e;

  // Clock source encoding shared by sw_target and cur_sel
  localparam logic SRC_CLK1 = 1'b0;
  localparam logic SRC_CLK2 = 1'b1;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int TIMEOUT_CNT_W      = 16;

endpackage

// File: rtl/clock_switch_ctrl_if.sv
// rtl/clock_switch_ctrl_if.sv - request side and selector handshake bundle of the clock switch controller
interface clock_switch_ctrl_if;

  logic sw_valid;
  logic sw_target;
  logic sw_ready;
  logic req_clk1;
  logic req_clk2;
  logic ack_clk1;
  logic ack_clk2;
  logic cur_sel;
  logic busy;
  logic timeout_err;

  // Requester plus clock selector side
  modport master (
    output sw_valid, sw_target, ack_clk1, ack_clk2,
    input  sw_ready, req_clk1, req_clk2, cur_sel, busy, timeout_err
  );

  // Controller side
  modport slave (
    input  sw_valid, sw_target, ack_clk1, ack_clk2,
    output sw_ready, req_clk1, req_clk2, cur_sel, busy, timeout_err
  );

endinterface

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for one asynchronous level input
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through STAGES flops, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - four-phase clock source switch controller (optional ack timeout: CLK_SW_TIMEOUT_EN)
module clock_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_switch_ctrl_if.slave   sw_if
);

  sw_state_e state_q, state_d;
  logic      target_q, target_d;
  logic      cur_sel_q, cur_sel_d;
  logic      req1_q, req1_d;
  logic      req2_q, req2_d;
  logic      busy_q, busy_d;
  logic      ready_q, ready_d;
  logic      ack1_s, ack2_s;
  logic      ack_tgt;
  logic      wait_expired;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack1 (
    .clk (clk),
    .rst (rst),
    .d_i (sw_if.ack_clk1),
    .q_o (ack1_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack2 (
    .clk (clk),
    .rst (rst),
    .d_i (sw_if.ack_clk2),
    .q_o (ack2_s)
  );

  // Only the channel being switched to is observed; the other ack is ignored
  assign ack_tgt = (target_q == SRC_CLK2) ? ack2_s : ack1_s;

`ifdef CLK_SW_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                     terr_q, terr_d;

  assign wait_expired = (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts on every state change and advances while waiting on an ack edge
  always_comb begin
    cnt_d  = '0;
    terr_d = (state_d == ST_ERR);
    if ((state_d == state_q) && ((state_q == ST_REQ_UP) || (state_q == ST_REQ_DN))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter and sticky error flag (ERR is left only through reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign sw_if.timeout_err = terr_q;
`else
  assign wait_expired      = 1'b0;
  assign sw_if.timeout_err = 1'b0;
`endif

  // Next state and next registered outputs of the handshake FSM
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sw_if.sw_valid && ready_q && (sw_if.sw_target != cur_sel_q)) begin
          target_d = sw_if.sw_target;
          state_d  = ST_REQ_UP;
        end
      end
      ST_REQ_UP: begin
        if (ack_tgt) begin
          state_d = ST_REQ_DN;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_REQ_DN: begin
        if (!ack_tgt) begin
          state_d   = ST_IDLE;
          cur_sel_d = target_q;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req1_d  = (state_d == ST_REQ_UP) && (target_d == SRC_CLK1);
    req2_d  = (state_d == ST_REQ_UP) && (target_d == SRC_CLK2);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= SRC_CLK1;
      cur_sel_q <= SRC_CLK1;
      req1_q    <= 1'b0;
      req2_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cur_sel_q <= cur_sel_d;
      req1_q    <= req1_d;
      req2_q    <= req2_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign sw_if.req_clk1 = req1_q;
  assign sw_if.req_clk2 = req2_q;
  assign sw_if.cur_sel  = cur_sel_q;
  assign sw_if.busy     = busy_q;
  assign sw_if.sw_ready = ready_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - self-checking bench for clock_switch_ctrl (timeout case under CLK_SW_TIMEOUT_EN)
module tb_clock_switch_ctrl;

  localparam int SYNC = 2;
  localparam int TMO  = 8;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   both_hi;

  // Selector model controls
  int       sel_delay;
  logic     stuck;
  logic     spur1, spur2;
  logic [7:0] hist1, hist2;
  logic     model_cur;

  clock_switch_ctrl_if sw_if ();

  clock_switch_ctrl #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_if (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selector: ack follows its req after sel_delay cycles (0 = same cycle)
  always @(posedge clk) begin
    hist1 <= {hist1[6:0], sw_if.req_clk1};
    hist2 <= {hist2[6:0], sw_if.req_clk2};
  end

  assign sw_if.ack_clk1 = spur1 | (!stuck & ((sel_delay == 0) ? sw_if.req_clk1 : hist1[sel_delay-1]));
  assign sw_if.ack_clk2 = spur2 | (!stuck & ((sel_delay == 0) ? sw_if.req_clk2 : hist2[sel_delay-1]));

  always @(negedge clk) begin
    if (sw_if.req_clk1 && sw_if.req_clk2) both_hi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw_if.sw_valid = 1'b0;
    stuck = 1'b0;
    spur1 = 1'b0;
    spur2 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
    model_cur = 1'b0;
  endtask

  // One switch request; a real switch must take 2*(delay+SYNC+1) edges after the accepting edge
  task automatic run_switch(input logic tgt, input int d, input bit spur, input bit busy_req);
    int   e;
    bit   done;
    int   other_hits;
    logic noop;
    sel_delay = d;
    noop = (tgt == model_cur);
    sw_if.sw_valid  = 1'b1;
    sw_if.sw_target = tgt;
    tick();
    sw_if.sw_valid = 1'b0;
    if (noop) begin
      check("noop_busy", sw_if.busy, 0);
      check("noop_ready", sw_if.sw_ready, 1);
      check("noop_req", sw_if.req_clk1 | sw_if.req_clk2, 0);
      repeat (3) tick();
      check("noop_quiet", sw_if.req_clk1 | sw_if.req_clk2 | sw_if.busy, 0);
      check("noop_cur_sel", sw_if.cur_sel, model_cur);
    end else begin
      check("up_req_tgt", tgt ? sw_if.req_clk2 : sw_if.req_clk1, 1);
      check("up_busy", sw_if.busy, 1);
      check("up_ready", sw_if.sw_ready, 0);
      e = 0;
      done = 1'b0;
      other_hits = 0;
      while (!done && e < 200) begin
        if (e == 2) begin
          if (spur) begin
            if (tgt) spur1 = 1'b1;
            else     spur2 = 1'b1;
          end
          if (busy_req) begin
            sw_if.sw_valid  = 1'b1;
            sw_if.sw_target = ~tgt;
          end
        end
        if (e == 3) begin
          spur1 = 1'b0;
          spur2 = 1'b0;
          sw_if.sw_valid = 1'b0;
        end
        tick();
        e++;
        if (tgt ? sw_if.req_clk1 : sw_if.req_clk2) other_hits++;
        if (!sw_if.busy) done = 1'b1;
      end
      check("sw_done", done, 1);
      check("sw_latency", e, 2 * (d + SYNC + 1));
      check("sw_cur_sel", sw_if.cur_sel, tgt);
      check("sw_ready_end", sw_if.sw_ready, 1);
      check("sw_req_low", sw_if.req_clk1 | sw_if.req_clk2, 0);
      check("sw_other_req", other_hits, 0);
      model_cur = tgt;
      repeat (3) tick();
      check("not_queued", sw_if.busy | sw_if.req_clk1 | sw_if.req_clk2, 0);
      check("cur_sel_hold", sw_if.cur_sel, model_cur);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    both_hi = 0;
    rst = 1'b1;
    sel_delay = 0;
    stuck = 1'b0;
    spur1 = 1'b0;
    spur2 = 1'b0;
    hist1 = '0;
    hist2 = '0;
    model_cur = 1'b0;
    sw_if.sw_valid  = 1'b0;
    sw_if.sw_target = 1'b0;
    tick();
    tick();

    // Values held during reset
    check("rst_ready", sw_if.sw_ready, 1);
    check("rst_req", {sw_if.req_clk1, sw_if.req_clk2}, 0);
    check("rst_cur_sel", sw_if.cur_sel, 0);
    check("rst_busy", sw_if.busy, 0);
    check("rst_terr", sw_if.timeout_err, 0);
    rst = 1'b0;
    tick();

    // Switch to clk2 with a selector answering after 3 cycles
    run_switch(1'b1, 3, 1'b0, 1'b0);
    // Same target again is a no-op
    run_switch(1'b1, 3, 1'b0, 1'b0);
    // Back to clk1 with an immediate selector (minimum latency)
    run_switch(1'b0, 0, 1'b0, 1'b0);
    // Request for clk1 while switching to clk2 is dropped
    run_switch(1'b1, 2, 1'b0, 1'b1);
    run_switch(1'b0, 1, 1'b0, 1'b0);
    // Spurious ack on clk1 during a clk2 switch
    run_switch(1'b1, 1, 1'b1, 1'b0);

    // Reset in REQ_UP drops req_clk2 and discards the switch
    do_reset();
    sel_delay = 4;
    sw_if.sw_valid  = 1'b1;
    sw_if.sw_target = 1'b1;
    tick();
    sw_if.sw_valid = 1'b0;
    tick();
    check("mid_req2", sw_if.req_clk2, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_req2", sw_if.req_clk2, 0);
    check("mid_rst_cur_sel", sw_if.cur_sel, 0);
    check("mid_rst_ready", sw_if.sw_ready, 1);
    check("mid_rst_busy", sw_if.busy, 0);
    // Reset wins over a simultaneous request
    sw_if.sw_valid  = 1'b1;
    sw_if.sw_target = 1'b1;
    tick();
    check("rst_prio_busy", sw_if.busy, 0);
    check("rst_prio_req2", sw_if.req_clk2, 0);
    sw_if.sw_valid = 1'b0;
    rst = 1'b0;
    repeat (8) tick();
    model_cur = 1'b0;

    // Randomized switches against the model
    for (int i = 0; i < 12; i++) begin
      run_switch(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Selector that never answers
    do_reset();
    stuck = 1'b1;
    sel_delay = 0;
    sw_if.sw_valid  = 1'b1;
    sw_if.sw_target = 1'b1;
    tick();
    sw_if.sw_valid = 1'b0;
`ifdef CLK_SW_TIMEOUT_EN
    repeat (TMO - 1) tick();
    check("tmo_req2_before", sw_if.req_clk2, 1);
    check("tmo_terr_before", sw_if.timeout_err, 0);
    tick();
    check("tmo_req2", sw_if.req_clk2, 0);
    check("tmo_terr", sw_if.timeout_err, 1);
    check("tmo_ready", sw_if.sw_ready, 0);
    check("tmo_busy", sw_if.busy, 1);
    repeat (20) tick();
    check("tmo_sticky", {sw_if.timeout_err, sw_if.sw_ready, sw_if.cur_sel}, 3'b100);
`else
    repeat (300) tick();
    check("nowait_req2", sw_if.req_clk2, 1);
    check("nowait_busy", sw_if.busy, 1);
    check("nowait_terr", sw_if.timeout_err, 0);
`endif
    do_reset();
    check("final_ready", sw_if.sw_ready, 1);
    check("final_terr", sw_if.timeout_err, 0);
    check("never_both_req", both_hi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
